// File: rtl/fec_rx_gather.sv
// fec_rx_gather: receive-side staging buffer in front of the FEC decoder.
// Symbols arrive one at a time with a slot index. They are assembled into a
// frame of M symbols, and the complete frame is then held on out_symbols
// until the decoder accepts it. Duplicate and out-of-range symbols are
// consumed, not stored, and counted in err_count.
// Optional feature: define FEC_RX_TIMEOUT_EN to enable an idle timeout. The
// timeout discards a partial frame that has stalled for TIMEOUT cycles and
// counts each expiry on timeout_count.
module fec_rx_gather #(
    parameter int M      = 3,
    parameter int WIDTH  = 11,
    parameter int DATA_W = WIDTH - 1,
    parameter int SLOT_W = (M > 1) ? $clog2(M) : 1,
    parameter int CNT_W  = 8
`ifdef FEC_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_symbol,
    input  logic [SLOT_W-1:0] in_slot,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_symbols [M],
    output logic [CNT_W-1:0]  err_count,
    output logic [M-1:0]      fill_map,
`ifdef FEC_RX_TIMEOUT_EN
    output logic [CNT_W-1:0]  timeout_count,
`endif
    output logic              dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready does not depend on in_valid. out_valid stays high, with its
    // data stable, until out_ready is seen.

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [M-1:0]       fill_q, fill_d;
    logic [M-1:0]       slot_oh;
    logic [DATA_W-1:0]  sym_q [M];
    logic [CNT_W-1:0]   err_q, err_d;
    logic               slot_ok;
    logic               fire;
    logic               store;
    logic               drop;
    logic               complete;
    logic               clear_fill;

    // Decode the slot index and classify the handshaken symbol.
    always_comb begin
        slot_oh = '0;
        for (int i = 0; i < M; i++) begin
            if (in_slot == SLOT_W'(i)) slot_oh[i] = 1'b1;
        end
        // An out-of-range slot decodes to an all-zero one-hot vector.
        slot_ok  = (|slot_oh) && !(|(fill_q & slot_oh));
        fire     = in_valid && in_ready;
        store    = fire && slot_ok;
        drop     = fire && !slot_ok;
        complete = store && ((fill_q | slot_oh) == {M{1'b1}});
    end

`ifdef FEC_RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic              expire;

    // Idle counter: runs only while a partial frame sits without progress.
    always_comb begin
        idle_d = '0;
        expire = 1'b0;
        tmo_d  = tmo_q;
        if (state_q == COLLECT && fill_q != '0 && !fire && !flush) begin
            if (idle_q == IDLE_W'(TIMEOUT - 1)) expire = 1'b1;
            else                                idle_d = idle_q + 1'b1;
        end
        if (expire && tmo_q != {CNT_W{1'b1}}) tmo_d = tmo_q + 1'b1;
        clear_fill = flush || expire;
    end

    // Idle and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
            tmo_q  <= '0;
        end else begin
            idle_q <= idle_d;
            tmo_q  <= tmo_d;
        end
    end

    assign timeout_count = tmo_q;
`else
    // Without the timeout feature, only an explicit flush drops a partial frame.
    always_comb begin
        clear_fill = flush;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= COLLECT;
        else        state_q <= state_d;
    end

    // FSM next state: fill until complete, then hold until the decoder accepts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (complete)  state_d = FULL;
            FULL:    if (out_ready) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // FSM outputs and observation ports.
    always_comb begin
        in_ready  = (state_q == COLLECT) && !flush;
        out_valid = (state_q == FULL);
        dbg_state = state_q;
        fill_map  = fill_q;
        err_count = err_q;
        for (int i = 0; i < M; i++) out_symbols[i] = sym_q[i];
    end

    // Next fill map and saturating error count.
    always_comb begin
        fill_d = fill_q;
        err_d  = err_q;
        if (state_q == FULL) begin
            if (out_ready) fill_d = '0;
        end else if (clear_fill) begin
            fill_d = '0;
        end else if (store) begin
            fill_d = fill_q | slot_oh;
        end
        if (drop && err_q != {CNT_W{1'b1}}) err_d = err_q + 1'b1;
    end

    // Fill map, error counter and symbol bank registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
            err_q  <= '0;
            for (int i = 0; i < M; i++) sym_q[i] <= '0;
        end else begin
            fill_q <= fill_d;
            err_q  <= err_d;
            for (int i = 0; i < M; i++) begin
                if (store && slot_oh[i]) sym_q[i] <= in_symbol;
            end
        end
    end

endmodule

// File: tb/tb_fec_rx_gather.sv
// Testbench for fec_rx_gather: directed scenarios followed by random traffic,
// all checked against a frame-level reference model.
module tb_fec_rx_gather;

  localparam int M = 3;
  localparam int DW = 10;
  localparam int TMO = 64;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_symbol;
  logic [1:0]    in_slot;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_symbols [M];
  logic [7:0]    err_count;
  logic [M-1:0]  fill_map;
  logic          dbg_state;
`ifdef FEC_RX_TIMEOUT_EN
  logic [7:0]    timeout_count;
`endif

  int checks = 0;
  int errors = 0;

  // reference model: frame contents, which slots hold data, frame-complete flag
  logic [DW-1:0] m_sym [M];
  bit   [M-1:0]  m_filled;
  bit            m_full;
  int            m_err;
  int            m_idle;
  int            m_tmo;

  fec_rx_gather dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_symbol(in_symbol),
    .in_slot(in_slot),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_symbols(out_symbols),
    .err_count(err_count),
    .fill_map(fill_map),
`ifdef FEC_RX_TIMEOUT_EN
    .timeout_count(timeout_count),
`endif
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < M; i++) m_sym[i] = '0;
    m_filled = '0;
    m_full   = 1'b0;
    m_err    = 0;
    m_idle   = 0;
    m_tmo    = 0;
  endtask

  // one clock of frame-level behaviour for the given inputs
  task automatic model_step(input bit v, input int sl, input logic [DW-1:0] sy,
                            input bit fl, input bit ordy);
    if (m_full) begin
      m_idle = 0;
      if (ordy) begin
        m_full   = 1'b0;
        m_filled = '0;
      end
    end else if (fl) begin
      m_idle   = 0;
      m_filled = '0;
    end else if (v) begin
      m_idle = 0;
      if (sl < M && !m_filled[sl]) begin
        m_sym[sl]    = sy;
        m_filled[sl] = 1'b1;
        if (m_filled == {M{1'b1}}) m_full = 1'b1;
      end else if (m_err < 255) begin
        m_err++;
      end
    end else if (m_filled != '0) begin
`ifdef FEC_RX_TIMEOUT_EN
      m_idle++;
      if (m_idle == TMO) begin
        m_filled = '0;
        m_idle   = 0;
        if (m_tmo < 255) m_tmo++;
      end
`endif
    end else begin
      m_idle = 0;
    end
  endtask

  task automatic check_outs(input string where);
    chk({where, ".out_valid"}, 32'(out_valid), 32'(m_full));
    chk({where, ".fill_map"}, 32'(fill_map), 32'(m_filled));
    chk({where, ".err_count"}, 32'(err_count), 32'(m_err));
    for (int i = 0; i < M; i++)
      chk($sformatf("%s.out_symbols[%0d]", where, i), 32'(out_symbols[i]), 32'(m_sym[i]));
`ifdef FEC_RX_TIMEOUT_EN
    chk({where, ".timeout_count"}, 32'(timeout_count), 32'(m_tmo));
`endif
  endtask

  // drive one cycle from a negedge, check in_ready combinationally, then outputs after the edge
  task automatic drive(input string where, input bit v, input int sl, input logic [DW-1:0] sy,
                       input bit fl, input bit ordy);
    in_valid  = v;
    in_slot   = 2'(sl);
    in_symbol = sy;
    flush     = fl;
    out_ready = ordy;
    #1;
    chk({where, ".in_ready"}, 32'(in_ready), 32'(!m_full && !fl));
    model_step(v, sl, sy, fl, ordy);
    @(posedge clk);
    @(negedge clk);
    check_outs(where);
  endtask

  task automatic idle(input string where, input int n);
    for (int i = 0; i < n; i++) drive(where, 1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_slot = '0;
    in_symbol = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("reset");
    rst_n = 1'b1;

    // out-of-order fill, held frame, then release
    drive("t1a", 1'b1, 2, 10'h155, 1'b0, 1'b0);
    drive("t1b", 1'b1, 0, 10'h0AA, 1'b0, 1'b0);
    drive("t1c", 1'b1, 1, 10'h3FF, 1'b0, 1'b0);
    chk("t1.full_now", 32'(out_valid), 32'd1);
    drive("t1hold", 1'b1, 0, 10'h111, 1'b0, 1'b0);
    drive("t1hold", 1'b1, 1, 10'h222, 1'b0, 1'b0);
    drive("t1rel", 1'b0, 0, '0, 1'b0, 1'b1);
    chk("t1.after_rel", 32'(out_valid), 32'd0);

    // duplicate slot and out-of-range slot are consumed and counted
    drive("t2a", 1'b1, 1, 10'h001, 1'b0, 1'b0);
    drive("t2b", 1'b1, 1, 10'h002, 1'b0, 1'b0);
    drive("t2c", 1'b1, 3, 10'h0F0, 1'b0, 1'b0);
    chk("t2.err", 32'(err_count), 32'd2);
    chk("t2.sym1", 32'(out_symbols[1]), 32'h001);
    chk("t2.fill", 32'(fill_map), 32'b010);

    // flush with a symbol presented in the same cycle
    drive("t3a", 1'b1, 0, 10'h0C3, 1'b0, 1'b0);
    drive("t3flush", 1'b1, 2, 10'h0C4, 1'b1, 1'b0);
    chk("t3.fill_cleared", 32'(fill_map), 32'd0);
    drive("t3b", 1'b1, 1, 10'h011, 1'b0, 1'b0);
    drive("t3c", 1'b1, 2, 10'h022, 1'b0, 1'b0);
    drive("t3d", 1'b1, 0, 10'h033, 1'b0, 1'b0);

    // flush ignored while a frame is held
    for (int i = 0; i < 5; i++) drive("t4flush", 1'b1, i % 3, 10'h3A5, 1'b1, 1'b0);
    chk("t4.held_sym0", 32'(out_symbols[0]), 32'h033);
    drive("t4rel", 1'b0, 0, '0, 1'b0, 1'b1);

    // error counter saturation
    drive("t5a", 1'b1, 0, 10'h1, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) drive("t5dup", 1'b1, 0, 10'(i), 1'b0, 1'b0);
    chk("t5.sat", 32'(err_count), 32'd255);
    drive("t5flush", 1'b0, 0, '0, 1'b1, 1'b0);

`ifdef FEC_RX_TIMEOUT_EN
    // stalled partial frame expires after TMO idle cycles; TMO-1 does not
    drive("t6a", 1'b1, 0, 10'h2AA, 1'b0, 1'b0);
    idle("t6idle", TMO);
    chk("t6.fill_expired", 32'(fill_map), 32'd0);
    chk("t6.tmo", 32'(timeout_count), 32'd1);
    drive("t6b", 1'b1, 1, 10'h055, 1'b0, 1'b0);
    idle("t6idle2", TMO - 1);
    drive("t6c", 1'b1, 2, 10'h066, 1'b0, 1'b0);
    chk("t6.no_expire", 32'(timeout_count), 32'd1);
    chk("t6.fill_kept", 32'(fill_map), 32'b110);
    drive("t6flush", 1'b0, 0, '0, 1'b1, 1'b0);
`else
    idle("t6idle", 10);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive("rnd",
            $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 3)),
            10'($urandom),
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) == 0);
    end
    if (m_full) drive("rnd_rel", 1'b0, 0, '0, 1'b0, 1'b1);

    // asynchronous reset in the middle of a partial frame
    drive("t7a", 1'b1, 1, 10'h123, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs("t7async");
    chk("t7.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive("t7post", 1'b1, 0, 10'h004, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
